// File: rtl/fifo_status.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, overflow/underflow error pulses and selectable FWFT read mode.
module fifo_status #(
   parameter int unsigned DATA_SIZE      = 8,
   parameter int unsigned ADDR_SPACE_EXP = 4,
   parameter int unsigned AF_LEVEL       = 14,
   parameter int unsigned AE_LEVEL       = 2,
   parameter bit          FWFT           = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write_to_fifo,
   input  logic                    read_from_fifo,
   input  logic [DATA_SIZE-1:0]    write_data_in,
   output logic [DATA_SIZE-1:0]    read_data_out,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [ADDR_SPACE_EXP:0] fill_count,
   output logic                    overflow,
   output logic                    underflow
);

   localparam int unsigned DEPTH = 2 ** ADDR_SPACE_EXP;
   localparam int unsigned CW    = ADDR_SPACE_EXP + 1;

   localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);
   localparam logic [CW-1:0] AfCnt    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AeCnt    = CW'(AE_LEVEL);

   logic [DATA_SIZE-1:0]      mem_q [DEPTH];
   logic [ADDR_SPACE_EXP-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_SPACE_EXP-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]             count_q, count_d;
   logic                      overflow_q, overflow_d;
   logic                      underflow_q, underflow_d;
   logic                      rd_ok, wr_ok;

   // Flags decode straight from the registered count so they all move together.
   assign fill_count   = count_q;
   assign full         = (count_q == DepthCnt);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AfCnt);
   assign almost_empty = (count_q <= AeCnt);
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // Acceptance decisions and next-state for pointers, count and error pulses.
   always_comb begin
      rd_ok       = read_from_fifo & ~empty;
      // A read in the same cycle frees a slot, so a full FIFO can still take a write.
      wr_ok       = write_to_fifo & (~full | rd_ok);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = write_to_fifo & ~wr_ok;
      underflow_d = read_from_fifo & ~rd_ok;
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + ADDR_SPACE_EXP'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + ADDR_SPACE_EXP'(1);
      end
      unique case ({wr_ok, rd_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage array; contents survive reset, only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (wr_ok && !reset) begin
         mem_q[wr_ptr_q] <= write_data_in;
      end
   end

   if (FWFT) begin : g_fwft
      // Head word is shown continuously; a read just pops it.
      assign read_data_out = mem_q[rd_ptr_q];
   end else begin : g_reg_read
      logic [DATA_SIZE-1:0] rdata_q;

      // Registered read: capture the head word on an accepted read, hold otherwise.
      always_ff @(posedge clk) begin
         if (reset) begin
            rdata_q <= '0;
         end else if (rd_ok) begin
            rdata_q <= mem_q[rd_ptr_q];
         end
      end

      assign read_data_out = rdata_q;
   end

endmodule

// File: tb/tb_fifo_status.sv
// Directed bench for fifo_status: a registered-read instance for the main
// scenarios and an FWFT instance for fall-through and mid-operation reset.
module tb_fifo_status;

   logic       clk = 1'b0;
   logic       reset;

   logic       wr0, rd0;
   logic [7:0] wd0, rdata0;
   logic       full0, empty0, af0, ae0, ovf0, unf0;
   logic [2:0] cnt0;

   logic       wr1, rd1;
   logic [7:0] wd1, rdata1;
   logic       full1, empty1, af1, ae1, ovf1, unf1;
   logic [2:0] cnt1;

   int tests = 0;
   int fails = 0;

   logic [7:0] exp_q [$];

   always #5 clk = ~clk;

   fifo_status #(
      .DATA_SIZE     (8),
      .ADDR_SPACE_EXP(2),
      .AF_LEVEL      (3),
      .AE_LEVEL      (1),
      .FWFT          (1'b0)
   ) u_dut0 (
      .clk           (clk),
      .reset         (reset),
      .write_to_fifo (wr0),
      .read_from_fifo(rd0),
      .write_data_in (wd0),
      .read_data_out (rdata0),
      .full          (full0),
      .empty         (empty0),
      .almost_full   (af0),
      .almost_empty  (ae0),
      .fill_count    (cnt0),
      .overflow      (ovf0),
      .underflow     (unf0)
   );

   fifo_status #(
      .DATA_SIZE     (8),
      .ADDR_SPACE_EXP(2),
      .AF_LEVEL      (3),
      .AE_LEVEL      (1),
      .FWFT          (1'b1)
   ) u_dut1 (
      .clk           (clk),
      .reset         (reset),
      .write_to_fifo (wr1),
      .read_from_fifo(rd1),
      .write_data_in (wd1),
      .read_data_out (rdata1),
      .full          (full1),
      .empty         (empty1),
      .almost_full   (af1),
      .almost_empty  (ae1),
      .fill_count    (cnt1),
      .overflow      (ovf1),
      .underflow     (unf1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; inputs change and checks happen 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: a read seen as acceptable before an edge produces data at that edge,
   // which is compared against the scoreboard at the following falling edge.
   initial begin : monitor
      logic pend;
      logic [7:0] exp_v;
      pend = 1'b0;
      forever begin
         @(negedge clk);
         if (pend) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL rdata_unexpected: got %0h expected no read data", rdata0);
            end else begin
               exp_v = exp_q.pop_front();
               check("rdata", {24'd0, rdata0}, {24'd0, exp_v});
            end
         end
         pend = rd0 & ~empty0 & ~reset;
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : driver
      logic [7:0] wvals [4];
      logic [3:0] exp_ae_t, exp_af_t, exp_full_t;
      logic [7:0] sim_in [6];
      logic [7:0] sim_out [6];
      wvals      = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      // Flag tables indexed by (count-1) for counts 1..4.
      exp_ae_t   = 4'b0001;
      exp_af_t   = 4'b1100;
      exp_full_t = 4'b1000;
      sim_in     = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
      sim_out    = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h10, 8'h11};

      reset = 1'b1;
      wr0 = 1'b0; rd0 = 1'b0; wd0 = '0;
      wr1 = 1'b0; rd1 = 1'b0; wd1 = '0;

      // 1. Reset state
      step();
      step();
      check("rst_empty", {31'd0, empty0}, 32'd1);
      check("rst_ae", {31'd0, ae0}, 32'd1);
      check("rst_full", {31'd0, full0}, 32'd0);
      check("rst_af", {31'd0, af0}, 32'd0);
      check("rst_count", {29'd0, cnt0}, 32'd0);
      check("rst_ovf", {31'd0, ovf0}, 32'd0);
      check("rst_unf", {31'd0, unf0}, 32'd0);
      check("rst_rdata", {24'd0, rdata0}, 32'd0);
      reset = 1'b0;

      // 2. Fill to full, then overflow
      for (int i = 0; i < 4; i++) begin
         wr0 = 1'b1;
         wd0 = wvals[i];
         step();
         check("fill_count", {29'd0, cnt0}, i + 1);
         check("fill_ae", {31'd0, ae0}, {31'd0, exp_ae_t[i]});
         check("fill_af", {31'd0, af0}, {31'd0, exp_af_t[i]});
         check("fill_full", {31'd0, full0}, {31'd0, exp_full_t[i]});
      end
      wd0 = 8'hEE;
      step();
      wr0 = 1'b0;
      check("ovf_pulse", {31'd0, ovf0}, 32'd1);
      check("ovf_count", {29'd0, cnt0}, 32'd4);
      step();
      check("ovf_clear", {31'd0, ovf0}, 32'd0);

      // 3. Drain with registered reads, then underflow
      for (int i = 0; i < 4; i++) begin
         rd0 = 1'b1;
         exp_q.push_back(wvals[i]);
         step();
      end
      check("drain_empty", {31'd0, empty0}, 32'd1);
      step();
      rd0 = 1'b0;
      check("unf_pulse", {31'd0, unf0}, 32'd1);
      check("unf_hold", {24'd0, rdata0}, 32'hD4);
      step();
      check("unf_clear", {31'd0, unf0}, 32'd0);

      // 4. Simultaneous read/write while full, across pointer wrap
      for (int i = 0; i < 4; i++) begin
         wr0 = 1'b1;
         wd0 = wvals[i];
         step();
      end
      check("refill_full", {31'd0, full0}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         wr0 = 1'b1;
         rd0 = 1'b1;
         wd0 = sim_in[i];
         exp_q.push_back(sim_out[i]);
         step();
         check("rw_count", {29'd0, cnt0}, 32'd4);
         check("rw_no_ovf", {31'd0, ovf0}, 32'd0);
      end
      wr0 = 1'b0;
      for (int i = 2; i < 6; i++) begin
         rd0 = 1'b1;
         exp_q.push_back(sim_in[i]);
         step();
      end
      rd0 = 1'b0;
      check("rw_drained", {31'd0, empty0}, 32'd1);

      // 5. Simultaneous read/write while empty
      wr0 = 1'b1;
      rd0 = 1'b1;
      wd0 = 8'h5A;
      step();
      wr0 = 1'b0;
      check("emp_rw_unf", {31'd0, unf0}, 32'd1);
      check("emp_rw_count", {29'd0, cnt0}, 32'd1);
      exp_q.push_back(8'h5A);
      step();
      rd0 = 1'b0;
      check("emp_rw_unf_clr", {31'd0, unf0}, 32'd0);
      check("emp_rw_empty", {31'd0, empty0}, 32'd1);
      step();

      // 6. FWFT fall-through and mid-operation reset
      check("fwft_init_empty", {31'd0, empty1}, 32'd1);
      wr1 = 1'b1;
      wd1 = 8'h77;
      step();
      wr1 = 1'b0;
      check("fwft_not_empty", {31'd0, empty1}, 32'd0);
      check("fwft_rdata", {24'd0, rdata1}, 32'h77);
      wr1 = 1'b1;
      wd1 = 8'h88;
      step();
      check("fwft_count2", {29'd0, cnt1}, 32'd2);
      check("fwft_head_kept", {24'd0, rdata1}, 32'h77);
      reset = 1'b1;
      wd1 = 8'h99;
      step();
      reset = 1'b0;
      wr1 = 1'b0;
      check("midrst_count", {29'd0, cnt1}, 32'd0);
      check("midrst_empty", {31'd0, empty1}, 32'd1);
      check("midrst_ovf", {31'd0, ovf1}, 32'd0);
      rd1 = 1'b1;
      step();
      rd1 = 1'b0;
      check("midrst_unf", {31'd0, unf1}, 32'd1);
      check("midrst_count2", {29'd0, cnt1}, 32'd0);

      step();
      step();
      check("scoreboard_drained", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fifo_status.md
Name: fifo_status

Overview:
Parametrised synchronous FIFO, successor to the basic fifo block. Adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between producer and consumer logic in the same clock domain, such as UART RX/TX buffering.

Parameters:
DATA_SIZE, 8, bits per data word
ADDR_SPACE_EXP, 4, address bits; DEPTH = 2**ADDR_SPACE_EXP words, all usable
AF_LEVEL, 14, almost_full asserts when fill_count >= AF_LEVEL (legal range 1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when fill_count <= AE_LEVEL (legal range 0..DEPTH-1)
FWFT, 0, read mode: 0 = registered read (1-cycle latency), 1 = first-word-fall-through

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
write_to_fifo  in  1  write request
read_from_fifo  in  1  read request
write_data_in  in  DATA_SIZE  write data, sampled on an accepted write
read_data_out  out  DATA_SIZE  read data (timing depends on FWFT)
full  out  1  fill_count == DEPTH
empty  out  1  fill_count == 0
almost_full  out  1  fill_count >= AF_LEVEL
almost_empty  out  1  fill_count <= AE_LEVEL
fill_count  out  ADDR_SPACE_EXP+1  number of stored words, 0..DEPTH
overflow  out  1  one-cycle pulse: write requested but rejected
underflow  out  1  one-cycle pulse: read requested but rejected

Behaviour:
- Reset behaviour:
  - Pointers and fill_count go to 0.
  - empty=1, full=0, almost_empty=1, almost_full=0.
  - overflow=0, underflow=0.
  - read_data_out=0 (FWFT=0).
  - Memory contents are not cleared.
  - A reset mid-operation discards all stored words and overrides any same-cycle request.
- Acceptance rules, evaluated on registered state:
  - rd_ok = read_from_fifo & ~empty
  - wr_ok = write_to_fifo & (~full | rd_ok)
- Accepted write: mem[wr_ptr] <= write_data_in; wr_ptr increments, wrapping modulo DEPTH.
- Accepted read: rd_ptr increments, wrapping modulo DEPTH.
- fill_count update:
  - +1 on wr_ok only.
  - -1 on rd_ok only.
  - Unchanged when both or neither occur.
- All flags are decoded from the registered fill_count. Every flag, and fill_count itself, updates on the clock edge after the causing request.
- Simultaneous read+write:
  - When full: both accepted; count stays DEPTH; order preserved.
  - When empty: write accepted, read rejected (underflow pulse); count becomes 1.
  - Otherwise: both accepted; count unchanged.
- FWFT=0:
  - read_data_out <= mem[rd_ptr] on rd_ok, so data is valid the cycle after the accepted read.
  - Holds its value otherwise, including on rejected reads.
- FWFT=1:
  - read_data_out = mem[rd_ptr] combinationally.
  - Valid whenever empty=0.
  - read_from_fifo acts as a pop/acknowledge of the shown word.
  - Value is don't-care while empty=1.
- Error pulses:
  - overflow <= write_to_fifo & ~wr_ok, registered, high for exactly one cycle per rejected request.
  - underflow <= read_from_fifo & ~rd_ok, same timing.
  - Rejected requests change no state.
- Back-to-back requests every cycle must sustain full throughput across pointer wrap-around.

Test Plan:
(All scenarios use DATA_SIZE=8, ADDR_SPACE_EXP=2, DEPTH=4, AF_LEVEL=3, AE_LEVEL=1.)
1. Assert reset for 2 cycles -> empty=1, almost_empty=1, full=0, almost_full=0, fill_count=0, overflow=0, underflow=0, read_data_out=00.
2. Write A1,B2,C3,D4 on consecutive cycles -> fill_count 1,2,3,4; almost_empty drops at count 2; almost_full rises at count 3; full rises at count 4. Then write EE -> overflow high for one cycle, fill_count stays 4, EE is never read back.
3. FWFT=0: read 4 times from full -> read_data_out shows A1,B2,C3,D4 one cycle after each read; empty=1 after the 4th read. A 5th read -> underflow pulse, read_data_out holds D4.
4. When full, hold write+read for 6 cycles with data 10..15 -> fill_count stays 4, no overflow, output sequence is A1,B2,C3,D4,10,11 (pointer wrap is verified).
5. When empty, assert write(5A)+read simultaneously -> underflow pulse, fill_count=1. The next read returns 5A.
6. FWFT=1: write 77 -> one cycle later empty=0 and read_data_out=77 with no read issued. Then write 88 and assert reset mid-operation -> next cycle fill_count=0, empty=1, and no pending data remains.
